// File: rtl/cp0_pkg.sv
// cp0_pkg: register numbers, exception codes and bit positions shared by the CP0 block
package cp0_pkg;
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [31:0] EXC_NONE    = 32'h0;
  localparam logic [31:0] EXC_INT0    = 32'h1;
  localparam logic [31:0] EXC_INT7    = 32'h8;
  localparam logic [31:0] EXC_SYSCALL = 32'h9;
  localparam logic [31:0] EXC_RI      = 32'hA;
  localparam logic [31:0] EXC_TRAP    = 32'hB;
  localparam logic [31:0] EXC_OV      = 32'hC;
  localparam logic [31:0] EXC_ERET    = 32'hD;
  localparam logic [4:0] CODE_INT = 5'd0;
  localparam logic [4:0] CODE_SYS = 5'd8;
  localparam logic [4:0] CODE_RI  = 5'd10;
  localparam logic [4:0] CODE_OV  = 5'd12;
  localparam logic [4:0] CODE_TR  = 5'd13;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int BD_BIT  = 31;
  localparam int IP_HI   = 15;
  localparam int IP_LO   = 8;
  localparam int EXC_HI  = 6;
  localparam int EXC_LO  = 2;
  function automatic logic [4:0] exc_code(input logic [31:0] t);
    return t == EXC_SYSCALL ? CODE_SYS :
           t == EXC_RI      ? CODE_RI  :
           t == EXC_TRAP    ? CODE_TR  :
           t == EXC_OV      ? CODE_OV  : CODE_INT;
  endfunction
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare and the sticky timer interrupt
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);
  // count ticks or loads; a Compare write clears the request, otherwise it latches on a match
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_o     <= '0;
      compare_o   <= '0;
      timer_int_o <= 1'b0;
    end else begin
      count_o <= we_i && waddr_i == REG_COUNT ? wdata_i : count_o + 32'd1;
      if (we_i && waddr_i == REG_COMPARE) begin
        compare_o   <= wdata_i;
        timer_int_o <= 1'b0;
      end else if (compare_o != '0 && count_o == compare_o) timer_int_o <= 1'b1;
    end
  end
endmodule

// File: rtl/cp0_regs.sv
// cp0_regs: Status/Cause/EPC with exception/eret update, mfc0/mtc0 and optional timer (CP0_TIMER_EN)
module cp0_regs
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_pc_i,
  input  logic        in_delayslot_i,
  output logic [31:0] rdata_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);
  logic [31:0] status, cause, epc, count, compare, new_pc, wval, rval, twval;
  logic        tint, exc, eret, flush;
  assign exc  = excepttype_i >= EXC_INT0 && excepttype_i <= EXC_OV;
  assign eret = excepttype_i == EXC_ERET;
`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk(clk), .rst_n(rst_n), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .count_o(count), .compare_o(compare), .timer_int_o(tint)
  );
  assign twval = wdata_i;
`else
  assign count   = '0;
  assign compare = '0;
  assign tint    = 1'b0;
  assign twval   = '0;
`endif
  // exception/eret updates take priority over mtc0 to Status, Cause and EPC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status <= STATUS_RST;
      cause  <= '0;
      epc    <= '0;
      flush  <= 1'b0;
      new_pc <= '0;
    end else begin
      flush  <= exc || eret;
      new_pc <= eret ? epc : EXC_VECTOR;
      cause[IP_HI:IP_LO+2] <= {int_i[5] | tint, int_i[4:0]};
      if (exc) begin
        if (!status[EXL_BIT]) begin
          epc           <= in_delayslot_i ? current_pc_i - 32'd4 : current_pc_i;
          cause[BD_BIT] <= in_delayslot_i;
        end
        status[EXL_BIT]       <= 1'b1;
        cause[EXC_HI:EXC_LO]  <= exc_code(excepttype_i);
      end else if (eret) status[EXL_BIT] <= 1'b0;
      else if (we_i) begin
        if (waddr_i == REG_STATUS) status <= wdata_i;
        if (waddr_i == REG_CAUSE) cause[IP_LO+1:IP_LO] <= wdata_i[IP_LO+1:IP_LO];
        if (waddr_i == REG_EPC) epc <= wdata_i;
      end
    end
  end
  // mfc0 mux with same-cycle bypass of the masked mtc0 value
  always_comb begin
    rval = raddr_i == REG_COUNT   ? count   :
           raddr_i == REG_COMPARE ? compare :
           raddr_i == REG_STATUS  ? status  :
           raddr_i == REG_CAUSE   ? cause   :
           raddr_i == REG_EPC     ? epc     : '0;
    wval = waddr_i == REG_COUNT || waddr_i == REG_COMPARE ? twval :
           waddr_i == REG_STATUS || waddr_i == REG_EPC    ? wdata_i :
           waddr_i == REG_CAUSE ? {cause[31:IP_LO+2], wdata_i[IP_LO+1:IP_LO], cause[IP_LO-1:0]} : '0;
    rdata_o = we_i && waddr_i == raddr_i ? wval : rval;
  end
  assign status_o    = status;
  assign cause_o     = cause;
  assign epc_o       = epc;
  assign timer_int_o = tint;
  assign flush_o     = flush;
  assign new_pc_o    = new_pc;
endmodule

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs: directed scoreboard bench for cp0_regs
module tb_cp0_regs;
  logic        clk = 1'b0;
  logic        rst_n, we_i, in_delayslot_i, timer_int_o, flush_o;
  logic [4:0]  waddr_i, raddr_i;
  logic [5:0]  int_i;
  logic [31:0] wdata_i, excepttype_i, current_pc_i;
  logic [31:0] rdata_o, status_o, cause_o, epc_o, new_pc_o;
  int tests = 0;
  int failed = 0;
  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  cp0_regs dut (
    .clk(clk), .rst_n(rst_n), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .int_i(int_i), .excepttype_i(excepttype_i),
    .current_pc_i(current_pc_i), .in_delayslot_i(in_delayslot_i),
    .rdata_o(rdata_o), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .timer_int_o(timer_int_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] b1(input logic x);
    return {31'b0, x};
  endfunction

  task automatic push(input string tag, input logic [31:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      failed++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        failed++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0;
    int_i = '0; excepttype_i = '0; current_pc_i = '0; in_delayslot_i = 1'b0;
    // reset
    push("rst_status", 32'h1000_0000); push("rst_cause", 32'h0); push("rst_epc", 32'h0);
    push("rst_flush", 32'h0); push("rst_timer", 32'h0); push("rst_newpc", 32'h0);
    step(); step();
    chk(status_o); chk(cause_o); chk(epc_o); chk(b1(flush_o)); chk(b1(timer_int_o)); chk(new_pc_o);
    // syscall, not in delay slot
    rst_n = 1'b1; excepttype_i = 32'h9; current_pc_i = 32'h1000;
    push("sys_epc", 32'h1000); push("sys_code", 32'd8); push("sys_bd", 32'h0);
    push("sys_status", 32'h1000_0002); push("sys_flush", 32'h1); push("sys_newpc", 32'hBFC0_0380);
    step();
    excepttype_i = '0;
    chk(epc_o); chk({27'b0, cause_o[6:2]}); chk(b1(cause_o[31])); chk(status_o); chk(b1(flush_o)); chk(new_pc_o);
    push("sys_flush_end", 32'h0);
    step();
    chk(b1(flush_o));
    // clear EXL via mtc0, then delay-slot overflow
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h1000_0000;
    push("mtc0_status", 32'h1000_0000);
    step();
    we_i = 1'b0;
    chk(status_o);
    excepttype_i = 32'hC; current_pc_i = 32'h2004; in_delayslot_i = 1'b1;
    push("ov_epc", 32'h2000); push("ov_bd", 32'h1); push("ov_code", 32'd12); push("ov_flush", 32'h1);
    step();
    chk(epc_o); chk(b1(cause_o[31])); chk({27'b0, cause_o[6:2]}); chk(b1(flush_o));
    // back-to-back RI while EXL=1 keeps EPC and BD
    excepttype_i = 32'hA; current_pc_i = 32'h5000; in_delayslot_i = 1'b0;
    push("ri_epc", 32'h2000); push("ri_code", 32'd10); push("ri_bd", 32'h1);
    push("ri_flush", 32'h1); push("ri_newpc", 32'hBFC0_0380);
    step();
    excepttype_i = '0;
    chk(epc_o); chk({27'b0, cause_o[6:2]}); chk(b1(cause_o[31])); chk(b1(flush_o)); chk(new_pc_o);
    push("ri_flush_end", 32'h0);
    step();
    chk(b1(flush_o));
    // eret back to a written EPC
    we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h3000;
    push("mtc0_epc", 32'h3000);
    step();
    we_i = 1'b0;
    chk(epc_o);
    excepttype_i = 32'hD;
    push("eret_status", 32'h1000_0000); push("eret_flush", 32'h1); push("eret_newpc", 32'h3000);
    step();
    excepttype_i = '0;
    chk(status_o); chk(b1(flush_o)); chk(new_pc_o);
    push("eret_flush_end", 32'h0);
    step();
    chk(b1(flush_o));
    // mtc0 Status collides with interrupt exception
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h0; excepttype_i = 32'h1; current_pc_i = 32'h4000;
    push("conf_status", 32'h1000_0002); push("conf_epc", 32'h4000); push("conf_code", 32'd0);
    step();
    we_i = 1'b0; excepttype_i = '0;
    chk(status_o); chk(epc_o); chk({27'b0, cause_o[6:2]});
    // masked Cause write with bypass
    we_i = 1'b1; waddr_i = 5'd13; wdata_i = 32'hFFFF_FFFF; raddr_i = 5'd13;
    #1;
    push("cause_bypass", 32'h0000_0300);
    chk(rdata_o);
    push("cause_write", 32'h0000_0300);
    step();
    we_i = 1'b0;
    chk(cause_o);
    // EPC bypass
    we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h55; raddr_i = 5'd14;
    #1;
    push("epc_bypass", 32'h55);
    chk(rdata_o);
    push("epc_write", 32'h55);
    step();
    we_i = 1'b0;
    chk(epc_o);
    #1;
    push("epc_read", 32'h55);
    chk(rdata_o);
    // unmapped register reads 0, even while written
    we_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'hDEAD_BEEF; raddr_i = 5'd3;
    #1;
    push("unmapped_read", 32'h0);
    chk(rdata_o);
    we_i = 1'b0;
    // hardware interrupt lines into IP[7:2]
    int_i = 6'b101010;
    push("cause_ip", 32'h0000_AB00);
    step();
    chk(cause_o);
    int_i = '0;
    step();
`ifdef CP0_TIMER_EN
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'd10;
    step();
    waddr_i = 5'd9; wdata_i = 32'd5;
    step();
    we_i = 1'b0; raddr_i = 5'd11;
    #1;
    push("compare_read", 32'd10);
    chk(rdata_o);
    repeat (4) step();
    push("timer_before", 32'h0);
    step();
    chk(b1(timer_int_o));
    push("timer_set", 32'h1); push("ip7_lag", 32'h0);
    step();
    chk(b1(timer_int_o)); chk(b1(cause_o[15]));
    push("ip7_set", 32'h1);
    step();
    chk(b1(cause_o[15]));
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'h0;
    push("timer_clear", 32'h0);
    step();
    we_i = 1'b0;
    chk(b1(timer_int_o));
`else
    we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'h1234; raddr_i = 5'd9;
    #1;
    push("count_bypass_zero", 32'h0);
    chk(rdata_o);
    step();
    we_i = 1'b0;
    push("count_read_zero", 32'h0); push("timer_tied", 32'h0);
    chk(rdata_o); chk(b1(timer_int_o));
    raddr_i = 5'd11;
    #1;
    push("compare_read_zero", 32'h0);
    chk(rdata_o);
`endif
    // reset asserted while a flush is pending
    excepttype_i = 32'h9;
    push("pre_rst_flush", 32'h1);
    step();
    chk(b1(flush_o));
    rst_n = 1'b0;
    push("rst_flush_clear", 32'h0); push("rst_status2", 32'h1000_0000); push("rst_epc2", 32'h0);
    step();
    chk(b1(flush_o)); chk(status_o); chk(epc_o);
    rst_n = 1'b1; excepttype_i = '0;
    if (sb.size() != 0) begin
      failed++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/cp0_regs.md
Name: cp0_regs

Overview:
- Coprocessor-0 register block; the consuming end of the exception-code path.
- Takes the prioritised exception code from the interrupt/exception handler, then updates Status, Cause and EPC, and redirects or flushes the pipeline.
- Sources cp0_status/cp0_cause back to the handler, which closes the loop.
- Also serves mtc0/mfc0 accesses and the Count/Compare timer.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, exception entry PC.
- STATUS_RST, 32'h1000_0000, Status reset value (CU0=1, EXL=0, IE=0).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- we_i  in  1  mtc0 write enable
- waddr_i  in  5  mtc0 register number
- wdata_i  in  32  mtc0 data
- raddr_i  in  5  mfc0 register number
- int_i  in  6  hardware interrupt lines, mapped to IP[7:2]
- excepttype_i  in  32  encoded code: 0 none; 1..8 IP0..IP7; 9 syscall; A RI; B trap; C overflow; D eret
- current_pc_i  in  32  PC of excepting instruction
- in_delayslot_i  in  1  excepting instruction is in a delay slot
- rdata_o  out  32  mfc0 read data (combinational)
- status_o  out  32  Status (reg 12)
- cause_o  out  32  Cause (reg 13)
- epc_o  out  32  EPC (reg 14)
- timer_int_o  out  1  timer interrupt request
- flush_o  out  1  pipeline flush pulse
- new_pc_o  out  32  redirect target, valid while flush_o=1

Behaviour:
- Reset (rst_n=0 at clk edge):
  - status_o=STATUS_RST.
  - cause_o, epc_o, Count, Compare = 0.
  - timer_int_o, flush_o = 0; new_pc_o=0.
- Cause[15:10] is loaded with int_i every cycle.
- Cause[9:8] (IP1..0) is written only by mtc0. All other Cause bits are set only by exception logic.
- mtc0 targets:
  - Count(9): full write.
  - Compare(11): full write; also clears timer_int_o.
  - Status(12): full write.
  - Cause(13): only bits 9:8 written.
  - EPC(14): full write.
  - Any other address: ignored.
- Count increments by 1 every cycle and wraps at 2^32. An mtc0 to Count loads wdata_i that cycle instead of incrementing.
- timer_int_o sets when Count==Compare and Compare!=0. It stays set until a Compare write.
- Exception accept (excepttype_i in 1..C), registered at the clk edge:
  - If Status.EXL=0:
    - EPC <= in_delayslot_i ? current_pc_i-4 : current_pc_i.
    - Cause.BD(31) <= in_delayslot_i.
  - If Status.EXL=1: EPC and BD are held.
  - Always: Status.EXL(1) <= 1.
  - Cause.ExcCode[6:2] <= 0 for codes 1..8, 8 for 9, 10 for A, 13 for B, 12 for C.
  - Next cycle: flush_o=1 for exactly 1 cycle; new_pc_o=EXC_VECTOR.
- ERET (code D): Status.EXL <= 0. Next cycle: flush_o=1, new_pc_o = EPC value at the eret edge.
- Codes E and above are treated as none.
- Simultaneous mtc0 and exception/eret: the exception update wins for Status, Cause and EPC; the mtc0 to those registers is dropped. mtc0 to Count/Compare still proceeds.
- Back-to-back exceptions: each produces its own flush pulse. The second keeps the first EPC, because EXL is already 1.
- rdata_o:
  - Combinational mux on raddr_i; unmapped addresses read 0.
  - Same-cycle bypass: if we_i and waddr_i==raddr_i, return the post-mask write value.
- Reset asserted mid-flush clears flush_o on that edge.

Optional Feature:
- Macro CP0_TIMER_EN.
- Defined: Count/Compare present. Cause.IP7(15) = int_i[5] | timer_int_o.
- Undefined:
  - Count and Compare are removed and read as 0; their writes are ignored.
  - timer_int_o is tied 0.
  - IP7 = int_i[5].

Decomposition:
- Package cp0_pkg holds:
  - CP0 register numbers (9, 11, 12, 13, 14).
  - Input exception codes 0..D.
  - ExcCode values (0, 8, 10, 12, 13).
  - Status/Cause bit indices (EXL=1, IE=0, BD=31, IP=15:8, ExcCode=6:2).
- One sub-module, cp0_timer: Count/Compare/timer_int_o, including mtc0 load and clear. Instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset check: rst_n=0 for 2 cycles -> status_o=32'h1000_0000, cause_o=0, epc_o=0, flush_o=0, timer_int_o=0.
- Syscall, not in delay slot:
  - Stimulus: excepttype_i=9, current_pc_i=32'h0000_1000, in_delayslot_i=0, EXL=0.
  - Response: epc_o=32'h1000, cause_o[6:2]=8, BD=0, status_o[1]=1.
  - Next cycle: flush_o=1 with new_pc_o=32'hBFC0_0380; the cycle after that flush_o=0.
- Delay-slot overflow:
  - Stimulus: excepttype_i=C, pc=32'h2004, in_delayslot_i=1.
  - Response: epc_o=32'h2000, cause_o[31]=1, ExcCode=12.
  - A follow-up code A while EXL=1 leaves epc_o=32'h2000 and sets ExcCode=10.
- ERET: EPC=32'h3000, excepttype_i=D -> status_o[1]=0 on the next edge; the following cycle flush_o=1 with new_pc_o=32'h3000.
- Timer:
  - Stimulus: mtc0 Compare=10, then mtc0 Count=5.
  - Response: timer_int_o=1 when Count reaches 10; cause_o[15]=1 one cycle later.
  - A Compare write clears timer_int_o.
  - Without CP0_TIMER_EN, rdata_o for reg 9 reads 0.
- Write conflict and bypass:
  - mtc0 Status=0 in the same cycle as excepttype_i=1 -> status_o[1]=1 and the mtc0 value is not applied.
  - mtc0 Cause=32'hFFFF_FFFF -> only cause_o[9:8]=2'b11 changes.
  - raddr_i=waddr_i=14 with wdata_i=32'h55 -> rdata_o=32'h55 the same cycle.
